// File: rtl/matrix_mac_sequencer.sv
// Sequencer for one MAC datapath that computes C = A x B over external
// row-major memories, writing each C element through a ready/valid port.
module matrix_mac_sequencer #(
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 40,
   parameter int ADDR_W  = 10,
   parameter int DIM_W   = 4,
   parameter int MAX_DIM = 8
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                cfg_start,
   input  logic                cfg_abort,
   input  logic [DIM_W-1:0]    cfg_m,
   input  logic [DIM_W-1:0]    cfg_k,
   input  logic [DIM_W-1:0]    cfg_n,
   input  logic [ADDR_W-1:0]   cfg_a_base,
   input  logic [ADDR_W-1:0]   cfg_b_base,
   input  logic [ADDR_W-1:0]   cfg_c_base,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                a_rd_en,
   output logic                b_rd_en,
   output logic [ADDR_W-1:0]   a_rd_addr,
   output logic [ADDR_W-1:0]   b_rd_addr,
   input  logic [DATA_W-1:0]   a_rd_data,
   input  logic [DATA_W-1:0]   b_rd_data,
   output logic                c_wr_en,
   output logic [ADDR_W-1:0]   c_wr_addr,
   output logic [ACC_W-1:0]    c_wr_data,
   input  logic                c_wr_ready
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] WRITE = 2'd3;

   localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);

   logic [1:0]               state;
   logic [DIM_W-1:0]         m_q, k_q, n_q;
   logic [DIM_W-1:0]         i_q, j_q, kc_q;
   logic [ADDR_W-1:0]        b_base_q;
   logic [ADDR_W-1:0]        a_ptr, b_ptr, a_row, b_col, c_ptr;
   logic [ACC_W-1:0]         acc;
   logic                     rd_vld, rd_first;
   logic                     done_q, err_q;

   logic signed [DATA_W-1:0]   a_s, b_s;
   logic signed [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]           prod_ext;
   logic                       bad_cfg;
   logic                       last_k, last_j, last_i;
   logic [ADDR_W-1:0]          n_ext, k_ext;

   assign a_s      = a_rd_data;
   assign b_s      = b_rd_data;
   assign prod     = a_s * b_s;
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

   assign bad_cfg = (cfg_m == '0) || (cfg_m > MAX_D) ||
                    (cfg_k == '0) || (cfg_k > MAX_D) ||
                    (cfg_n == '0) || (cfg_n > MAX_D);

   assign last_k = (kc_q == k_q - 1'b1);
   assign last_j = (j_q == n_q - 1'b1);
   assign last_i = (i_q == m_q - 1'b1);
   assign n_ext  = ADDR_W'(n_q);
   assign k_ext  = ADDR_W'(k_q);

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state    <= IDLE;
         m_q      <= '0;
         k_q      <= '0;
         n_q      <= '0;
         i_q      <= '0;
         j_q      <= '0;
         kc_q     <= '0;
         b_base_q <= '0;
         a_ptr    <= '0;
         b_ptr    <= '0;
         a_row    <= '0;
         b_col    <= '0;
         c_ptr    <= '0;
         acc      <= '0;
         rd_vld   <= 1'b0;
         rd_first <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         rd_vld <= 1'b0;
         if (rd_vld)
            acc <= rd_first ? prod_ext : acc + prod_ext;
         // an abort also drops rd_vld, so an in-flight read is ignored
         if (state != IDLE && cfg_abort) begin
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: if (cfg_start) begin
                  m_q      <= cfg_m;
                  k_q      <= cfg_k;
                  n_q      <= cfg_n;
                  b_base_q <= cfg_b_base;
                  a_ptr    <= cfg_a_base;
                  a_row    <= cfg_a_base;
                  b_ptr    <= cfg_b_base;
                  b_col    <= cfg_b_base;
                  c_ptr    <= cfg_c_base;
                  i_q      <= '0;
                  j_q      <= '0;
                  kc_q     <= '0;
                  if (bad_cfg) err_q <= 1'b1;
                  else         state <= FETCH;
               end
               FETCH: begin
                  rd_vld   <= 1'b1;
                  rd_first <= (kc_q == '0);
                  a_ptr    <= a_ptr + 1'b1;
                  b_ptr    <= b_ptr + n_ext;
                  if (last_k) begin
                     kc_q  <= '0;
                     state <= DRAIN;
                  end else begin
                     kc_q  <= kc_q + 1'b1;
                  end
               end
               DRAIN: state <= WRITE;
               WRITE: if (c_wr_ready) begin
                  c_ptr <= c_ptr + 1'b1;
                  state <= FETCH;
                  if (last_j) begin
                     j_q   <= '0;
                     i_q   <= i_q + 1'b1;
                     a_row <= a_row + k_ext;
                     a_ptr <= a_row + k_ext;
                     b_col <= b_base_q;
                     b_ptr <= b_base_q;
                     if (last_i) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                     end
                  end else begin
                     j_q   <= j_q + 1'b1;
                     a_ptr <= a_row;
                     b_col <= b_col + 1'b1;
                     b_ptr <= b_col + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy      = (state != IDLE);
   assign a_rd_en   = (state == FETCH);
   assign b_rd_en   = (state == FETCH);
   assign a_rd_addr = a_ptr;
   assign b_rd_addr = b_ptr;
   assign c_wr_en   = (state == WRITE);
   assign c_wr_addr = c_ptr;
   assign c_wr_data = acc;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Randomized self-checking bench for matrix_mac_sequencer against a
// plain matrix-product reference with modelled operand memories.
module tb_matrix_mac_sequencer;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cfg_start, cfg_abort;
   logic [3:0]  cfg_m, cfg_k, cfg_n;
   logic [9:0]  cfg_a_base, cfg_b_base, cfg_c_base;
   logic        busy, done, err;
   logic        a_rd_en, b_rd_en;
   logic [9:0]  a_rd_addr, b_rd_addr;
   logic [15:0] a_rd_data, b_rd_data;
   logic        c_wr_en;
   logic [9:0]  c_wr_addr;
   logic [39:0] c_wr_data;
   logic        c_wr_ready;

   matrix_mac_sequencer dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
      .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base),
      .cfg_c_base(cfg_c_base),
      .busy(busy), .done(done), .err(err),
      .a_rd_en(a_rd_en), .b_rd_en(b_rd_en),
      .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
      .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
      .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr),
      .c_wr_data(c_wr_data), .c_wr_ready(c_wr_ready)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [9:0]  addr;
      logic [39:0] data;
   } wr_t;

   logic [15:0] mem_a [1024];
   logic [15:0] mem_b [1024];
   int          ma [8][8];
   int          mb [8][8];
   wr_t         exp_q[$];

   int n_chk = 0;
   int n_err = 0;
   int busy_cyc, done_cnt, err_cnt, rd_cnt, wr_cnt, stalls;
   int rdy_mode = 0;
   int stall_left = 0;
   logic        prev_stall = 1'b0;
   logic [9:0]  prev_addr;
   logic [39:0] prev_data;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // operand memories: data one cycle after the strobe, junk otherwise
   always @(posedge ACLK) begin
      a_rd_data <= a_rd_en ? mem_a[a_rd_addr] : 16'($urandom);
      b_rd_data <= b_rd_en ? mem_b[b_rd_addr] : 16'($urandom);
   end

   initial begin
      c_wr_ready = 1'b1;
      forever begin
         @(posedge ACLK);
         #1;
         case (rdy_mode)
            1: c_wr_ready = ($urandom_range(0, 2) != 0);
            2: begin
               c_wr_ready = !(c_wr_en && wr_cnt == 1 && stall_left > 0);
               if (!c_wr_ready) stall_left--;
            end
            default: c_wr_ready = 1'b1;
         endcase
      end
   end

   always @(negedge ACLK) begin
      if (ARESET) begin
         prev_stall = 1'b0;
      end else begin
         if (busy) busy_cyc++;
         if (err) err_cnt++;
         if (done) begin
            done_cnt++;
            chk("done_with_busy", busy, 0);
         end
         if (a_rd_en || b_rd_en) begin
            rd_cnt++;
            chk("rd_pair", b_rd_en, a_rd_en);
         end
         if (prev_stall) begin
            chk("hold_addr", c_wr_addr, prev_addr);
            chk("hold_data", c_wr_data, prev_data);
         end
         if (c_wr_en && !c_wr_ready) begin
            stalls++;
            if (a_rd_en) chk("rd_in_stall", a_rd_en, 0);
         end
         prev_stall = c_wr_en && !c_wr_ready;
         prev_addr  = c_wr_addr;
         prev_data  = c_wr_data;
         if (c_wr_en && c_wr_ready) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               chk("wr_extra", 1, 0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", c_wr_addr, e.addr);
               chk("wr_data", c_wr_data, e.data);
            end
         end
      end
   end

   task automatic clear_counts();
      busy_cyc = 0; done_cnt = 0; err_cnt = 0;
      rd_cnt = 0; wr_cnt = 0; stalls = 0;
   endtask

   task automatic fill_rand(input int m, input int k, input int n);
      for (int r = 0; r < m; r++)
         for (int c = 0; c < k; c++)
            ma[r][c] = $urandom_range(0, 65535) - 32768;
      for (int r = 0; r < k; r++)
         for (int c = 0; c < n; c++)
            mb[r][c] = $urandom_range(0, 65535) - 32768;
   endtask

   // load memories and build the expected write stream
   task automatic prep_op(input int m, input int k, input int n,
                          input int ab, input int bb, input int cb);
      exp_q.delete();
      for (int r = 0; r < m; r++)
         for (int c = 0; c < k; c++)
            mem_a[(ab + r*k + c) % 1024] = 16'(ma[r][c]);
      for (int r = 0; r < k; r++)
         for (int c = 0; c < n; c++)
            mem_b[(bb + r*n + c) % 1024] = 16'(mb[r][c]);
      for (int r = 0; r < m; r++)
         for (int c = 0; c < n; c++) begin
            longint s = 0;
            wr_t w;
            for (int x = 0; x < k; x++)
               s += longint'(ma[r][x]) * longint'(mb[x][c]);
            w.addr = 10'((cb + r*n + c) % 1024);
            w.data = s[39:0];
            exp_q.push_back(w);
         end
      clear_counts();
   endtask

   task automatic start_op(input int m, input int k, input int n,
                           input int ab, input int bb, input int cb,
                           input bit with_abort);
      @(posedge ACLK);
      #1;
      cfg_m = 4'(m); cfg_k = 4'(k); cfg_n = 4'(n);
      cfg_a_base = 10'(ab); cfg_b_base = 10'(bb); cfg_c_base = 10'(cb);
      cfg_start = 1'b1;
      cfg_abort = with_abort;
      @(posedge ACLK);
      #1;
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      cfg_m = 4'($urandom); cfg_k = 4'($urandom); cfg_n = 4'($urandom);
      cfg_a_base = 10'($urandom); cfg_b_base = 10'($urandom);
      cfg_c_base = 10'($urandom);
   endtask

   task automatic run_op(input int m, input int k, input int n,
                         input int ab, input int bb, input int cb,
                         input bit poke, input bit with_abort);
      int cyc = 0;
      prep_op(m, k, n, ab, bb, cb);
      start_op(m, k, n, ab, bb, cb, with_abort);
      while (done_cnt == 0 && cyc < 3000) begin
         @(posedge ACLK);
         #1;
         cyc++;
         cfg_start = (poke && cyc == 5);
      end
      cfg_start = 1'b0;
      repeat (3) @(posedge ACLK);
      #1;
      chk("done_cnt", done_cnt, 1);
      chk("busy_cyc", busy_cyc, m*n*(k+2) + stalls);
      chk("rd_cnt", rd_cnt, m*n*k);
      chk("wr_cnt", wr_cnt, m*n);
      chk("q_left", exp_q.size(), 0);
      chk("no_err", err_cnt, 0);
   endtask

   task automatic bad_start(input int m, input int k, input int n);
      clear_counts();
      @(posedge ACLK);
      #1;
      cfg_m = 4'(m); cfg_k = 4'(k); cfg_n = 4'(n);
      cfg_start = 1'b1;
      @(posedge ACLK);
      #1;
      cfg_start = 1'b0;
      @(negedge ACLK);
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      repeat (5) @(posedge ACLK);
      #1;
      chk("err_cnt", err_cnt, 1);
      chk("err_busy_cyc", busy_cyc, 0);
      chk("err_rd", rd_cnt, 0);
      chk("err_wr", wr_cnt, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int x = 0; x < 1024; x++) begin
         mem_a[x] = 16'($urandom);
         mem_b[x] = 16'($urandom);
      end
      ARESET = 1'b1;
      cfg_start = 1'b0; cfg_abort = 1'b0;
      cfg_m = '0; cfg_k = '0; cfg_n = '0;
      cfg_a_base = '0; cfg_b_base = '0; cfg_c_base = '0;
      clear_counts();
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk("rst_ctrl", {busy, done, err, a_rd_en, b_rd_en, c_wr_en}, 0);
      chk("rst_addr", {a_rd_addr, b_rd_addr, c_wr_addr}, 0);
      chk("rst_data", c_wr_data, 0);
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;

      // 2x2x2 reference case
      ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
      mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
      run_op(2, 2, 2, 'h000, 'h010, 'h020, 0, 0);
      chk("busy_2x2x2", busy_cyc, 16);

      // column vector times scalar, signed results
      ma[0][0] = 2; ma[1][0] = -3; ma[2][0] = 4; mb[0][0] = -5;
      run_op(3, 1, 1, 'h100, 'h200, 'h300, 0, 0);
      chk("busy_k1", busy_cyc, 9);

      // three-cycle stall on the second write
      ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
      mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
      rdy_mode = 2;
      stall_left = 3;
      run_op(2, 2, 2, 'h000, 'h010, 'h020, 0, 0);
      chk("stall_n", stalls, 3);
      chk("busy_stall", busy_cyc, 19);
      rdy_mode = 0;

      bad_start(0, 2, 2);
      bad_start(2, 9, 2);

      // start pulse mid-operation is ignored
      run_op(2, 2, 2, 'h000, 'h010, 'h020, 1, 0);

      // abort mid-operation
      fill_rand(4, 4, 4);
      prep_op(4, 4, 4, 'h040, 'h080, 'h0c0);
      start_op(4, 4, 4, 'h040, 'h080, 'h0c0, 0);
      repeat (9) @(posedge ACLK);
      #1;
      cfg_abort = 1'b1;
      @(posedge ACLK);
      #1;
      cfg_abort = 1'b0;
      @(negedge ACLK);
      chk("abort_busy", busy, 0);
      chk("abort_wr", c_wr_en, 0);
      repeat (5) @(posedge ACLK);
      #1;
      chk("abort_done", done_cnt, 0);
      chk("abort_err", err_cnt, 0);
      exp_q.delete();
      fill_rand(4, 4, 4);
      run_op(4, 4, 4, 'h040, 'h080, 'h0c0, 0, 0);

      // reset in the middle of FETCH
      fill_rand(3, 3, 3);
      prep_op(3, 3, 3, 'h3fe, 'h3fd, 'h3ff);
      start_op(3, 3, 3, 'h3fe, 'h3fd, 'h3ff, 0);
      ARESET = 1'b1;
      @(posedge ACLK);
      @(negedge ACLK);
      chk("mrst_ctrl", {busy, done, err, a_rd_en, b_rd_en, c_wr_en}, 0);
      chk("mrst_addr", {a_rd_addr, b_rd_addr, c_wr_addr}, 0);
      chk("mrst_data", c_wr_data, 0);
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      clear_counts();
      repeat (4) @(posedge ACLK);
      #1;
      chk("mrst_done", done_cnt, 0);
      exp_q.delete();

      // randomized sweep, with wrapping bases and random ready
      for (int t = 0; t < 12; t++) begin
         int m = $urandom_range(1, 8);
         int k = $urandom_range(1, 8);
         int n = $urandom_range(1, 8);
         rdy_mode = $urandom_range(0, 1);
         fill_rand(m, k, n);
         run_op(m, k, n, $urandom_range(0, 1023), $urandom_range(0, 1023),
                $urandom_range(0, 1023), 0, (t == 3));
      end
      rdy_mode = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/matrix_mac_sequencer.md
Name: matrix_mac_sequencer

Overview:
Sequences a single multiply-accumulate datapath to compute C = A x B over matrices held in external single-port-read memories. Programmed from the matrix_controller AXI4-Lite register file through dimensions, base addresses and a start pulse. Issues operand reads, accumulates products internally and writes each C element through a ready/valid write port. Returns status as busy, done and err.

Parameters:
DATA_W, 16, signed operand width of A and B elements
ACC_W, 40, signed accumulator and C element width
ADDR_W, 10, word address width of the A, B and C memories
DIM_W, 4, width of the dimension fields
MAX_DIM, 8, largest legal value of M, K and N

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
cfg_start  in  1  single-cycle start request
cfg_abort  in  1  abort the current operation
cfg_m, cfg_k, cfg_n  in  DIM_W each  dimensions: A is MxK, B is KxN
cfg_a_base, cfg_b_base, cfg_c_base  in  ADDR_W each  base word addresses
busy  out  1  operation in progress
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse when a start is rejected
a_rd_en, b_rd_en  out  1 each  operand read strobes
a_rd_addr, b_rd_addr  out  ADDR_W each  operand addresses
a_rd_data, b_rd_data  in  DATA_W each  operand data, valid exactly 1 cycle after the strobe
c_wr_en  out  1  result valid
c_wr_addr  out  ADDR_W  result address
c_wr_data  out  ACC_W  result data
c_wr_ready  in  1  result accepted when high together with c_wr_en

Behaviour:
- Reset: state IDLE; all outputs 0; accumulator, counters and latched configuration 0. Reset mid-operation abandons the work, with no done and no pending write.
- Storage layout is row-major. A[i][k] is at a_base+i*K+k; B[k][j] is at b_base+k*N+j; C[i][j] is at c_base+i*N+j.
- Addresses come from incrementing pointers (no multipliers) and wrap modulo 2^ADDR_W.
- States: IDLE, FETCH, DRAIN, WRITE.
- IDLE:
  - On cfg_start, dimensions and bases are latched.
  - If any of M, K, N is 0 or greater than MAX_DIM, err pulses the next cycle and the block stays IDLE with no reads.
  - Otherwise the next state is FETCH with i=j=k=0 and busy=1.
- FETCH: one cycle per k, K cycles total.
  - a_rd_en=b_rd_en=1 with the current addresses.
  - The A pointer increments by 1 and the B pointer by N.
  - After k=K-1 the next state is DRAIN.
- Accumulation:
  - Data returns one cycle after each strobe. The k=0 return loads acc=a*b; later returns add a*b.
  - The product is a signed full-precision 2*DATA_W result, sign-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W; there is no saturation.
- DRAIN: one cycle with no strobes; the last product is accumulated here.
- WRITE:
  - c_wr_en=1 with c_wr_addr=c_base+i*N+j and c_wr_data=acc.
  - Address and data hold stable until c_wr_ready.
  - On acceptance, j advances. At j=N-1, j returns to 0 and i advances. The operand pointers reload for the next element and the next state is FETCH.
  - After the final element (i=M-1, j=N-1) the next state is IDLE, busy drops and done pulses in that same cycle.
- Timing: each element takes K+2 cycles with ready held high. A full operation is busy for M*N*(K+2) cycles.
- Stalls: each cycle of c_wr_ready low adds one cycle; no reads are issued while stalled.
- cfg_start while busy is ignored, and latched configuration is unaffected.
- cfg_abort while busy (any state):
  - Next cycle: IDLE, busy=0, c_wr_en=0, no done, no err.
  - Any read returning after the abort is discarded.
  - cfg_abort in IDLE has no effect. Simultaneous cfg_start and cfg_abort in IDLE: start wins.
- Configuration input changes during an operation have no effect.

Test Plan:
- 2x2x2 with A=[1,2;3,4] at 0x000, B=[5,6;7,8] at 0x010, C base 0x020, ready always 1 -> writes (0x020,19),(0x021,22),(0x022,43),(0x023,50) in that order; busy high exactly 16 cycles; one done pulse.
- K=1, M=3, N=1, A=[2,-3,4], B=[-5] -> C = -10, 15, -20; each element takes 3 cycles; signed results are sign-extended to ACC_W.
- 2x2x2 case with c_wr_ready low for 3 cycles on the second write -> c_wr_addr stays 0x021 and c_wr_data stays 22 throughout; no read strobes during the stall; busy=19 cycles; results identical.
- cfg_m=0, then cfg_k=9 (MAX_DIM=8) -> each start gives one err pulse; busy never rises; no rd_en or c_wr_en.
- cfg_start pulsed mid-operation -> ignored; outputs identical to the uninterrupted run.
- 4x4x4 run with cfg_abort on cycle 10 -> busy=0 and c_wr_en=0 the next cycle, no done. A subsequent start runs cleanly. A repeat with ARESET asserted mid-FETCH also shows all outputs 0 the next cycle.
